// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } state_e;

  // A scan result: valid=0 means no key was seen.
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_t;

  localparam key_t       KEY_NONE  = '{valid: 1'b0, code: 4'h0};
  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Press/release debouncer fed once per full keypad scan; emits a one-cycle accept.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       scan_done_i,
  input  logic       result_valid_i,
  input  logic [3:0] result_code_i,
  output logic       accept_o,
  output logic [3:0] accept_code_o
);

  localparam int             CW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  N_C   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0]  ONE_C = CW'(1);
  localparam logic [CW-1:0]  ZERO_C = CW'(0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + ONE_C;

  // State register; cnt_q counts matching scans in DEB and empty scans in HELD.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= ZERO_C;
      cand_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state and accept decode, evaluated only when a scan completes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cand_d        = cand_q;
    accept_o      = 1'b0;
    accept_code_o = cand_q;
    if (scan_done_i) begin
      case (state_q)
        IDLE: begin
          if (result_valid_i) begin
            cand_d = result_code_i;
            if (DEBOUNCE_SCANS == 1) begin
              accept_o      = 1'b1;
              accept_code_o = result_code_i;
              state_d       = HELD;
              cnt_d         = ZERO_C;
            end else begin
              state_d = DEB;
              cnt_d   = ONE_C;
            end
          end else begin
            cnt_d = ZERO_C;
          end
        end
        DEB: begin
          if (!result_valid_i) begin
            state_d = IDLE;
            cnt_d   = ZERO_C;
          end else if (result_code_i == cand_q) begin
            if (cnt_inc_s == N_C) begin
              accept_o = 1'b1;
              state_d  = HELD;
              cnt_d    = ZERO_C;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            cand_d = result_code_i;
            cnt_d  = ONE_C;
          end
        end
        HELD: begin
          if (result_valid_i) begin
            cnt_d = ZERO_C;
          end else if (cnt_inc_s == N_C) begin
            state_d = IDLE;
            cnt_d   = ZERO_C;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = ZERO_C;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

endmodule

// File: rtl/keypad_scan_32.sv
// 4x4 keypad scanner: column drive, row sync, scan-result capture and a
// 32-bit digit shift register feeding the hex display driver.
module keypad_scan_32
  import keypad_pkg::*;
#(
  parameter int SCAN_CLOCKS    = 200_000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic [3:0]  ROW,
  input  logic        clr_i,
  output logic [3:0]  COL,
  output logic [31:0] data_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o
);

  localparam int            SW        = $clog2(SCAN_CLOCKS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CLOCKS - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [SW-1:0] SLOT_ZERO = SW'(0);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q, col_d;
  key_t          part_q, part_d;
  logic [31:0]   data_q, data_d;
  logic          key_valid_q;
  logic [3:0]    key_code_q, key_code_d;

  logic          slot_last_s;
  logic          scan_done_s;
  key_t          col_hit_s;
  key_t          merged_s;
  logic [31:0]   data_base_s;
  logic          accept_s;
  logic [3:0]    accept_code_s;

  assign slot_last_s = (slot_q == SLOT_LAST);
  assign scan_done_s = slot_last_s && (col_idx_q == 2'd3);

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= ROW;
      row_sync_q <= row_meta_q;
    end
  end

  // Slot counter and one-hot-low column rotation.
  always_comb begin
    if (slot_last_s) begin
      slot_d    = SLOT_ZERO;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[2:0], col_q[3]};
    end else begin
      slot_d    = slot_q + SLOT_ONE;
      col_idx_d = col_idx_q;
      col_d     = col_q;
    end
  end

  // Lowest active row in the currently driven column.
  always_comb begin
    col_hit_s = KEY_NONE;
    if (!row_sync_q[0]) begin
      col_hit_s = '{valid: 1'b1, code: key_code(2'd0, col_idx_q)};
    end else if (!row_sync_q[1]) begin
      col_hit_s = '{valid: 1'b1, code: key_code(2'd1, col_idx_q)};
    end else if (!row_sync_q[2]) begin
      col_hit_s = '{valid: 1'b1, code: key_code(2'd2, col_idx_q)};
    end else if (!row_sync_q[3]) begin
      col_hit_s = '{valid: 1'b1, code: key_code(2'd3, col_idx_q)};
    end else begin
      col_hit_s = KEY_NONE;
    end
  end

  // Earlier columns win; column 0 starts a fresh scan.
  always_comb begin
    if (col_idx_q == 2'd0) begin
      merged_s = col_hit_s;
    end else if (part_q.valid) begin
      merged_s = part_q;
    end else begin
      merged_s = col_hit_s;
    end
    if (slot_last_s) begin
      part_d = merged_s;
    end else begin
      part_d = part_q;
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk            (clk),
    .rst_n_i        (rst_n_i),
    .scan_done_i    (scan_done_s),
    .result_valid_i (merged_s.valid),
    .result_code_i  (merged_s.code),
    .accept_o       (accept_s),
    .accept_code_o  (accept_code_s)
  );

  // Clear happens first so a coincident accept lands in an empty register.
  always_comb begin
    if (clr_i) begin
      data_base_s = 32'h0000_0000;
    end else begin
      data_base_s = data_q;
    end
    if (accept_s) begin
      data_d     = {data_base_s[27:0], accept_code_s};
      key_code_d = accept_code_s;
    end else begin
      data_d     = data_base_s;
      key_code_d = key_code_q;
    end
  end

  // Scan position, partial result and output registers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_q      <= SLOT_ZERO;
      col_idx_q   <= 2'd0;
      col_q       <= COL_RESET;
      part_q      <= KEY_NONE;
      data_q      <= 32'h0000_0000;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      part_q      <= part_d;
      data_q      <= data_d;
      key_valid_q <= accept_s;
      key_code_q  <= key_code_d;
    end
  end

  assign COL         = col_q;
  assign data_o      = data_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: tb/tb_keypad_scan_32.sv
// Self-checking bench: a physical keypad model drives ROW from COL and a
// per-scan reference model predicts pulses, key code and displayed digits.
module tb_keypad_scan_32;

  localparam int SC  = 4;
  localparam int DS  = 3;
  localparam int SCAN_CYC = 4 * SC;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [3:0]  ROW;
  logic        clr_i;
  logic [3:0]  COL;
  logic [31:0] data_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;

  logic [15:0] pressed;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int g_pulses = 0;

  // reference model state: 0 idle, 1 debouncing, 2 held
  int          m_state;
  int          m_cand;
  int          m_cnt;
  logic [31:0] m_data;
  logic [3:0]  m_code;

  keypad_scan_32 #(.SCAN_CLOCKS(SC), .DEBOUNCE_SCANS(DS)) dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .ROW         (ROW),
    .clr_i       (clr_i),
    .COL         (COL),
    .data_o      (data_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o)
  );

  always #5 clk = ~clk;

  // key 4r+c pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) ROW[r] = ~|(pressed[4*r +: 4] & ~COL);
  end

  function automatic int scan_result(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[4*r + c]) return 4*r + c;
    return -1;
  endfunction

  function automatic logic [15:0] key_bit(input int k);
    logic [15:0] one;
    one = 16'h0001;
    return one << k;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cand = 0; m_cnt = 0;
    m_data = 32'h0; m_code = 4'h0;
  endtask

  // Asynchronous reset mid-cycle, released on a falling edge so scans align.
  task automatic apply_reset(input bit check_now);
    @(posedge clk); #3;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    if (check_now) begin
      chk_cnt++;
      if (COL !== 4'b1110) $display("FAIL reset_col: got %b want 1110", COL); else pass_cnt++;
      chk_cnt++;
      if (data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", data_o); else pass_cnt++;
      chk_cnt++;
      if (key_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid_o); else pass_cnt++;
      chk_cnt++;
      if (key_code_o !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code_o); else pass_cnt++;
    end
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // One full scan with the given keys held; checks the pulse lands exactly on
  // the cycle after the column-3 sample, and the visible outputs afterwards.
  task automatic do_scan(input logic [15:0] mask, input bit clr, input string tag);
    int res;
    bit acc;
    int pulses;
    bit bad_pos;
    res = scan_result(mask);
    acc = 1'b0;
    pulses = 0;
    bad_pos = 1'b0;
    if (res < 0) begin
      if (m_state == 2) begin
        m_cnt++;
        if (m_cnt >= DS) begin m_state = 0; m_cnt = 0; end
      end else begin
        m_state = 0; m_cnt = 0;
      end
    end else if (m_state == 2) begin
      m_cnt = 0;
    end else begin
      if (m_state == 1 && res == m_cand) m_cnt++;
      else begin m_cand = res; m_cnt = 1; end
      m_state = 1;
      if (m_cnt >= DS) begin acc = 1'b1; m_state = 2; m_cnt = 0; end
    end
    if (clr) m_data = 32'h0;
    if (acc) begin
      m_data = {m_data[27:0], 4'(res)};
      m_code = 4'(res);
    end
    pressed = mask;
    for (int j = 0; j < SCAN_CYC; j++) begin
      if (clr && j == SCAN_CYC - 1) clr_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_i = 1'b0;
      if (key_valid_o === 1'b1) begin
        pulses++;
        if (j != SCAN_CYC - 1) bad_pos = 1'b1;
      end
    end
    g_pulses += pulses;
    chk_cnt++;
    if (pulses != (acc ? 1 : 0) || bad_pos)
      $display("FAIL %s_pulse: got %0d pulses (misplaced=%0d) want %0d", tag, pulses, bad_pos, acc ? 1 : 0);
    else pass_cnt++;
    chk_cnt++;
    if (data_o !== m_data) $display("FAIL %s_data: got %h want %h", tag, data_o, m_data); else pass_cnt++;
    chk_cnt++;
    if (key_code_o !== m_code) $display("FAIL %s_code: got %h want %h", tag, key_code_o, m_code); else pass_cnt++;
  endtask

  task automatic press_release(input int k, input string tag);
    for (int s = 0; s < DS; s++) do_scan(key_bit(k), 1'b0, tag);
    for (int s = 0; s < DS; s++) do_scan(16'h0, 1'b0, tag);
  endtask

  task automatic test_reset();
    int idx;
    pressed = 16'h0;
    apply_reset(1'b1);
    for (int j = 0; j < 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      idx = ((j + 1) / SC) % 4;
      chk_cnt++;
      if (COL !== ~(4'b0001 << idx)) $display("FAIL col_rotate: cycle %0d got %b want %b", j, COL, ~(4'b0001 << idx));
      else pass_cnt++;
    end
    // realign to a scan boundary after 32 = 2 full scans
  endtask

  task automatic test_single_key();
    int p0;
    p0 = g_pulses;
    for (int s = 0; s < 5; s++) do_scan(key_bit(6), 1'b0, "single");
    for (int s = 0; s < DS; s++) do_scan(16'h0, 1'b0, "single_rel");
    chk_cnt++;
    if (g_pulses - p0 != 1) $display("FAIL single_count: got %0d want 1", g_pulses - p0); else pass_cnt++;
    chk_cnt++;
    if (data_o !== 32'h0000_0006) $display("FAIL single_value: got %h want 00000006", data_o); else pass_cnt++;
  endtask

  task automatic test_bounce();
    int p0;
    p0 = g_pulses;
    do_scan(key_bit(5), 1'b0, "bounce");
    do_scan(key_bit(5), 1'b0, "bounce");
    do_scan(16'h0, 1'b0, "bounce");
    for (int s = 0; s < 3; s++) do_scan(key_bit(5), 1'b0, "bounce");
    for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0, "bounce");
    chk_cnt++;
    if (g_pulses - p0 != 1) $display("FAIL bounce_count: got %0d want 1", g_pulses - p0); else pass_cnt++;
  endtask

  task automatic test_sequence();
    int p0;
    p0 = g_pulses;
    for (int k = 1; k <= 9; k++) press_release(k, "seq");
    chk_cnt++;
    if (g_pulses - p0 != 9) $display("FAIL seq_count: got %0d want 9", g_pulses - p0); else pass_cnt++;
    chk_cnt++;
    if (data_o !== 32'h2345_6789) $display("FAIL seq_value: got %h want 23456789", data_o); else pass_cnt++;
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = g_pulses;
    for (int s = 0; s < DS; s++) do_scan(key_bit(3) | key_bit(9), 1'b0, "multi");
    for (int s = 0; s < DS; s++) do_scan(key_bit(3) | key_bit(9) | key_bit(12), 1'b0, "multi_held");
    for (int s = 0; s < DS; s++) do_scan(16'h0, 1'b0, "multi_rel");
    chk_cnt++;
    if (g_pulses - p0 != 1) $display("FAIL multi_count: got %0d want 1", g_pulses - p0); else pass_cnt++;
    chk_cnt++;
    if (key_code_o !== 4'h9) $display("FAIL multi_code: got %h want 9", key_code_o); else pass_cnt++;
  endtask

  task automatic test_clear();
    do_scan(16'h0, 1'b1, "clr_idle");
    for (int k = 1; k <= 8; k++) press_release(k, "clr_fill");
    chk_cnt++;
    if (data_o !== 32'h1234_5678) $display("FAIL clr_fill: got %h want 12345678", data_o); else pass_cnt++;
    do_scan(key_bit(10), 1'b0, "clr_acc");
    do_scan(key_bit(10), 1'b0, "clr_acc");
    do_scan(key_bit(10), 1'b1, "clr_acc");
    chk_cnt++;
    if (data_o !== 32'h0000_000A) $display("FAIL clr_accept: got %h want 0000000a", data_o); else pass_cnt++;
    for (int s = 0; s < DS; s++) do_scan(16'h0, 1'b0, "clr_rel");
  endtask

  task automatic test_reset_mid();
    int p0;
    int early;
    p0 = g_pulses;
    early = 0;
    do_scan(key_bit(7), 1'b0, "rmid");
    do_scan(key_bit(7), 1'b0, "rmid");
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid_o === 1'b1) early++;
    end
    apply_reset(1'b0);
    chk_cnt++;
    if (early != 0 || key_valid_o !== 1'b0) $display("FAIL rmid_nopulse: got %0d pulses want 0", early); else pass_cnt++;
    for (int s = 0; s < DS; s++) do_scan(key_bit(7), 1'b0, "rmid_again");
    for (int s = 0; s < DS; s++) do_scan(16'h0, 1'b0, "rmid_rel");
    chk_cnt++;
    if (g_pulses - p0 != 1) $display("FAIL rmid_count: got %0d want 1", g_pulses - p0); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int len;
    int kind;
    for (int run = 0; run < 25; run++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       mask = 16'h0;
        3:       mask = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
        default: mask = key_bit($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 4);
      for (int s = 0; s < len; s++) do_scan(mask, ($urandom_range(0, 7) == 0), "rand");
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    clr_i   = 1'b0;
    pressed = 16'h0;
    model_reset();
    test_reset();
    test_single_key();
    test_bounce();
    test_sequence();
    test_multi_key();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
